// File: rtl/display_nav_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : display_nav_ctrl_if
// Description : Bundle of the button / receiver inputs and the display
//               selection outputs of display_nav_ctrl.
//   Signals   : btn_mode, btn_right, btn_left - raw asynchronous buttons
//               rx_valid    - one-cycle strobe, new byte stored in rxbuf
//               auto_follow - level, rx_valid jumps view to rx byte 0
//               mode        - 0 = tx view, 1 = rx view
//               index[1:0]  - byte index shown
//               digit_sel[1:0] - digit currently scanned, 0 = rightmost
//               an[3:0]     - active-low anode enables
//               rx_pending  - unseen received data flag
//   Modports  : master (stimulus side), slave (display_nav_ctrl side)
// Revision    : 1.0 - initial release
// ============================================================================
interface display_nav_ctrl_if;
  logic       btn_mode;
  logic       btn_right;
  logic       btn_left;
  logic       rx_valid;
  logic       auto_follow;
  logic       mode;
  logic [1:0] index;
  logic [1:0] digit_sel;
  logic [3:0] an;
  logic       rx_pending;

  modport master (
    output btn_mode, btn_right, btn_left, rx_valid, auto_follow,
    input  mode, index, digit_sel, an, rx_pending
  );

  modport slave (
    input  btn_mode, btn_right, btn_left, rx_valid, auto_follow,
    output mode, index, digit_sel, an, rx_pending
  );
endinterface
`default_nettype wire

// File: rtl/display_nav_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : display_nav_ctrl
// Description : Control block for the 7-segment buffer viewer. Debounces the
//               board buttons, selects which buffer (tx/rx) and byte index
//               is shown, tracks unseen rx data and drives the anode scan.
//   Ports     : clk   - system clock, rising edge
//               reset - synchronous, active-high
//               bus   - display_nav_ctrl_if.slave (buttons, rx strobe,
//                       mode/index/digit_sel/an/rx_pending outputs)
//   Params    : DEBOUNCE_CYCLES - stable samples to accept a level (>= 2)
//               SCAN_CYCLES     - cycles each digit stays active (>= 1)
// Revision    : 1.0 - initial release
// ============================================================================
module display_nav_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int SCAN_CYCLES     = 100000
) (
  input  wire logic          clk,
  input  wire logic          reset,
  display_nav_ctrl_if.slave  bus
);

  localparam int c_DB_W   = $clog2(DEBOUNCE_CYCLES);
  localparam int c_SCAN_W = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam logic [c_DB_W-1:0]   c_DB_LAST   = c_DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_SCAN_W-1:0] c_SCAN_LAST = c_SCAN_W'(SCAN_CYCLES - 1);

  localparam int c_BTN_MODE  = 0;
  localparam int c_BTN_RIGHT = 1;
  localparam int c_BTN_LEFT  = 2;
  localparam int c_NUM_BTN   = 3;

  // --------------------------------------------------------------------------
  // Button conditioning: sync -> debounce -> rising-edge event
  // --------------------------------------------------------------------------
  logic [c_NUM_BTN-1:0] w_btn_raw;
  logic [c_NUM_BTN-1:0] w_ev;

  assign w_btn_raw[c_BTN_MODE]  = bus.btn_mode;
  assign w_btn_raw[c_BTN_RIGHT] = bus.btn_right;
  assign w_btn_raw[c_BTN_LEFT]  = bus.btn_left;

  for (genvar gi = 0; gi < c_NUM_BTN; gi++) begin : g_btn
    logic              r_s1;
    logic              r_s2;
    logic              r_db;
    logic              r_db_q;
    logic [c_DB_W-1:0] r_cnt;
    logic              r_ev;

    always_ff @(posedge clk) begin
      if (reset) begin
        r_s1   <= 1'b0;
        r_s2   <= 1'b0;
        r_db   <= 1'b0;
        r_db_q <= 1'b0;
        r_cnt  <= '0;
        r_ev   <= 1'b0;
      end else begin
        r_s1   <= w_btn_raw[gi];
        r_s2   <= r_s1;
        r_db_q <= r_db;
        // The event is taken from the registered debounced level, so a press
        // surfaces one cycle after db itself rises. Releases give no event.
        r_ev   <= r_db & ~r_db_q;
        if (r_s2 == r_db) begin
          r_cnt <= '0;
        end else if (r_cnt == c_DB_LAST) begin
          r_db  <= r_s2;
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end

    assign w_ev[gi] = r_ev;
  end

  // --------------------------------------------------------------------------
  // Navigation
  // --------------------------------------------------------------------------
  logic       r_mode;
  logic [1:0] r_index;
  logic       r_rx_pending;
  logic       w_mode_nxt;
  logic [1:0] w_index_nxt;

  always_comb begin
    w_mode_nxt  = r_mode;
    w_index_nxt = r_index;
    if (bus.rx_valid && bus.auto_follow) begin
      // Auto-follow overrides every button event in the same cycle.
      w_mode_nxt  = 1'b1;
      w_index_nxt = 2'd0;
    end else begin
      if (w_ev[c_BTN_MODE]) begin
        w_mode_nxt = ~r_mode;
      end
      // Mode toggle does not block index movement; opposing presses cancel.
      if (w_ev[c_BTN_RIGHT] && !w_ev[c_BTN_LEFT]) begin
        w_index_nxt = r_index + 2'd1;
      end else if (w_ev[c_BTN_LEFT] && !w_ev[c_BTN_RIGHT]) begin
        w_index_nxt = r_index - 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mode       <= 1'b0;
      r_index      <= 2'd0;
      r_rx_pending <= 1'b0;
    end else begin
      r_mode  <= w_mode_nxt;
      r_index <= w_index_nxt;
      // Being in (or entering) rx view means the data is being looked at.
      if (r_mode || w_mode_nxt) begin
        r_rx_pending <= 1'b0;
      end else if (bus.rx_valid) begin
        r_rx_pending <= 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Anode scan scheduler, free-running and independent of navigation
  // --------------------------------------------------------------------------
  logic [c_SCAN_W-1:0] r_scan_cnt;
  logic [1:0]          r_digit_sel;
  logic [3:0]          r_an;
  logic [1:0]          w_digit_nxt;

  function automatic logic [3:0] f_anode(input logic [1:0] sel);
    return ~(4'b0001 << sel);
  endfunction

  assign w_digit_nxt = r_digit_sel + 2'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_scan_cnt  <= '0;
      r_digit_sel <= 2'd0;
      r_an        <= 4'b1110;
    end else if (r_scan_cnt == c_SCAN_LAST) begin
      r_scan_cnt  <= '0;
      r_digit_sel <= w_digit_nxt;
      // Decoded from the next digit so an and digit_sel change together.
      r_an        <= f_anode(w_digit_nxt);
    end else begin
      r_scan_cnt  <= r_scan_cnt + 1'b1;
    end
  end

  assign bus.mode       = r_mode;
  assign bus.index      = r_index;
  assign bus.digit_sel  = r_digit_sel;
  assign bus.an         = r_an;
  assign bus.rx_pending = r_rx_pending;

endmodule
`default_nettype wire

// File: doc/display_nav_ctrl.md
Name: display_nav_ctrl

Overview:
- Control block for the 7-segment buffer viewer in the UART project.
- Takes raw board buttons and the receiver's byte-valid strobe, and decides which buffer (tx/rx) and which byte index the display datapath shows.
- Generates the anode scan schedule and the digit-select for the segment mux.
- The datapath only decodes `mode`/`index`/`digit_sel` into segments.

Parameters:
DEBOUNCE_CYCLES, 1000000, consecutive stable synchronized samples required to accept a button level change (10 ms at 100 MHz); must be >= 2
SCAN_CYCLES, 100000, clock cycles each digit is held active before advancing; must be >= 1

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
btn_mode  input  1  raw asynchronous button: toggle tx/rx view
btn_right  input  1  raw asynchronous button: index +1
btn_left  input  1  raw asynchronous button: index -1
rx_valid  input  1  one-cycle strobe from receiver, a new byte was stored in rxbuf
auto_follow  input  1  level, when high a rx_valid forces view to rx byte 0
mode  output  1  0 = tx buffer view, 1 = rx buffer view
index  output  2  byte index shown, 0..3
digit_sel  output  2  digit currently scanned, 0 = rightmost
an  output  4  active-low anode enables
rx_pending  output  1  unseen received data flag

Behaviour:
- Reset (synchronous, active-high):
  - mode=0, index=0, digit_sel=0, an=4'b1110, rx_pending=0.
  - All synchronizers, debounce counters, debounced levels and event pulses cleared to 0.
  - Scan counter cleared to 0.
  - Reset asserted mid-debounce or mid-scan discards all progress.
- Input conditioning, per button, identical instances:
  - Two-flop synchronizer gives s2.
  - Debounced level db and counter cnt.
  - If s2==db: cnt<=0.
  - Else if cnt==DEBOUNCE_CYCLES-1: db<=s2, cnt<=0.
  - Else: cnt<=cnt+1.
  - Event pulse ev is registered and high for exactly one cycle on a db 0->1 transition only. Releases produce no event.
  - Latency: ev is high in the cycle beginning DEBOUNCE_CYCLES+2 rising edges after the first edge that samples the raw input high, provided the raw input stays high throughout.
  - A glitch shorter than DEBOUNCE_CYCLES samples produces no event.
  - Holding a button produces exactly one event.
- Navigation, evaluated each cycle from that cycle's ev_mode, ev_right, ev_left, rx_valid. Priority, highest first:
  1. rx_valid && auto_follow: mode<=1, index<=0. All button events in the same cycle are dropped.
  2. ev_mode: mode<=~mode; index unchanged. A simultaneous ev_right/ev_left in the same cycle is still applied.
  3. ev_right && ev_left together: index unchanged.
  4. ev_right: index<=index+1, wrapping 3->0.
  5. ev_left: index<=index-1, wrapping 0->3.
- rx_pending:
  - Set when rx_valid and the resulting mode is 0.
  - Cleared in any cycle where mode is (or becomes) 1.
  - Set and clear in the same cycle: clear wins, because the only set condition requires resulting mode 0.
  - rx_valid while already in rx view leaves it 0.
- Scan scheduler:
  - Free-running counter 0..SCAN_CYCLES-1.
  - On the cycle it wraps to 0, digit_sel<=digit_sel+1, wrapping 3->0.
  - an is a registered decode, updated together with digit_sel:
    - digit_sel 0 -> 1110
    - digit_sel 1 -> 1101
    - digit_sel 2 -> 1011
    - digit_sel 3 -> 0111
  - Exactly one anode is low at all times, including during reset.
  - Scan is independent of navigation. A mode/index change never resets the scan counter.
- All outputs are registered; no combinational path from any input to any output.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, SCAN_CYCLES=3.
1. Reset, then run 24 cycles -> an sequence 1110,1101,1011,0111 repeating, each held 3 cycles; digit_sel 0,1,2,3 in step; mode=0, index=0.
2. btn_right high from cycle 10, held for 20 cycles -> single ev_right; index 0->1 exactly once, visible 7 cycles after the first sampling edge. Repeat 3 more times -> index 2,3,0 (wrap).
3. From index=0, btn_left press -> index=3. A 2-cycle btn_left glitch -> index unchanged.
4. btn_right and btn_left debounced on the same cycle -> index unchanged. btn_mode debounced on the same cycle as btn_right -> mode toggles and index +1.
5. auto_follow=0, mode=0, rx_valid pulse -> rx_pending=1, mode stays 0. btn_mode press -> mode=1, rx_pending=0.
6. auto_follow=1, mode=0, index=2, rx_valid coincident with ev_right -> mode=1, index=0, rx_pending=0. Reset asserted mid-debounce of btn_right -> no event after release of reset.
